// File: rtl/usr_deserializer.sv
// ---------------------------------------------------------------------------
// usr_deserializer
//
// Serial-to-parallel receiver. It collects framed serial bit streams into
// WIDTH-bit words, either LSB-first or MSB-first. Each completed word is
// placed in a single-entry holding register and offered to the consumer
// through a valid/ready handshake. A word that completes while the holding
// register is full and is not being drained is dropped, and this sets a
// sticky overrun flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   ena        input-side enable; when low, start/ser_valid are ignored
//   start      frame start pulse; restarts the bit counter
//   dir        bit order, sampled together with start (0 LSB-first, 1 MSB-first)
//   ser_in     serial data bit
//   ser_valid  ser_in is valid this cycle
//   out_ready  consumer accepts par_out
//   ovr_clr    clears the overrun flag
//   par_out    received word (holding register)
//   out_valid  par_out holds an unconsumed word
//   busy       a frame is being received
//   overrun    sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module usr_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             dir,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             done;
    logic             drop;

    // Shifting towards index 0 for LSB-first leaves the first bit at index 0
    // once WIDTH bits have arrived; shifting towards the MSB for MSB-first
    // leaves the first bit at index WIDTH-1.
    function automatic logic [WIDTH-1:0] shiftIn(input logic [WIDTH-1:0] word,
                                                 input logic msbFirst,
                                                 input logic bitIn);
        if (msbFirst) begin
            return {word[WIDTH-2:0], bitIn};
        end
        return {bitIn, word[WIDTH-1:1]};
    endfunction

    // Receive side: start always wins and restarts the frame; a ser_valid in
    // the same cycle becomes bit 0 of the new frame. The WIDTH-th bit
    // completes the word and returns the FSM to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        dir_d   = dir_q;
        done    = 1'b0;
        if (ena) begin
            if (start) begin
                state_d = RECV;
                dir_d   = dir;
                cnt_d   = '0;
                asm_d   = '0;
                if (ser_valid) begin
                    asm_d = shiftIn('0, dir, ser_in);
                    cnt_d = CW'(1);
                end
            end else if (state_q == RECV && ser_valid) begin
                asm_d = shiftIn(asm_q, dir_q, ser_in);
                if (cnt_q == LAST_BIT) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Output side: a completed word goes into the holding register if it is
    // empty or being drained on this same edge; otherwise it is dropped and
    // overrun is set. Setting overrun takes priority over clearing it.
    always_comb begin
        par_d   = par_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (done) begin
            if (!valid_q || out_ready) begin
                par_d   = asm_d;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        ovr_d = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end
        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            dir_q   <= 1'b0;
            par_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            dir_q   <= dir_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign par_out   = par_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_usr_deserializer.sv
// ---------------------------------------------------------------------------
// tb_usr_deserializer
//
// Self-checking bench for usr_deserializer. A behavioural model keeps the
// bits of the current frame in a queue and builds the word arithmetically
// once WIDTH bits have been collected; the holding register, handshake and
// overrun flag are modelled from the receiver's rules. Directed frames
// are followed by a long run of random stimulus.
// ---------------------------------------------------------------------------
module tb_usr_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         start;
    logic         dir;
    logic         ser_in;
    logic         ser_valid;
    logic         out_ready;
    logic         ovr_clr;
    logic [W-1:0] par_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit           mBusy;
    bit           mDir;
    bit           mBits[$];
    bit   [W-1:0] mPar;
    bit           mValid;
    bit           mOvr;

    usr_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .dir       (dir),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .par_out   (par_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic resetModel();
        mBusy  = 1'b0;
        mDir   = 1'b0;
        mBits.delete();
        mPar   = '0;
        mValid = 1'b0;
        mOvr   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit         complete;
        bit [W-1:0] word;
        complete = 1'b0;
        word     = '0;
        if (ena) begin
            if (start) begin
                mBusy = 1'b1;
                mDir  = dir;
                mBits.delete();
                if (ser_valid) mBits.push_back(ser_in);
            end else if (mBusy && ser_valid) begin
                mBits.push_back(ser_in);
                if (mBits.size() == W) begin
                    for (int k = 0; k < W; k++) begin
                        if (mBits[k]) word = word | (W'(1) << (mDir ? (W - 1 - k) : k));
                    end
                    complete = 1'b1;
                    mBits.delete();
                    mBusy = 1'b0;
                end
            end
        end
        if (complete && mValid && !out_ready) begin
            mOvr = 1'b1;
        end else begin
            if (ovr_clr) mOvr = 1'b0;
            if (complete) begin
                mPar   = word;
                mValid = 1'b1;
            end else if (mValid && out_ready) begin
                mValid = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input bit st, input bit d, input bit sv, input bit si,
                                 input bit rdy, input bit clr);
        ena       = 1'b1;
        start     = st;
        dir       = d;
        ser_valid = sv;
        ser_in    = si;
        out_ready = rdy;
        ovr_clr   = clr;
    endtask

    // One clock: update the model, take the edge, compare all outputs.
    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("par_out", par_out, mPar);
        checkOutput("out_valid", out_valid, mValid);
        checkOutput("busy", busy, mBusy);
        checkOutput("overrun", overrun, mOvr);
    endtask

    // Start cycle followed by WIDTH back-to-back bits; rdyLast applies only
    // to the completing bit.
    task automatic sendFrame(input bit [W-1:0] word, input bit d, input bit rdyBody, input bit rdyLast);
        applyStimulus(1'b1, d, 1'b0, 1'b0, rdyBody, 1'b0);
        cycle();
        for (int k = 0; k < W; k++) begin
            applyStimulus(1'b0, d, 1'b1, d ? word[W-1-k] : word[k],
                          (k == W - 1) ? rdyLast : rdyBody, 1'b0);
            cycle();
        end
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
        cycle();
    endtask

    initial begin
        bit [W-1:0] w81;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        resetModel();
        #12;
        checkOutput("reset par_out", par_out, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;

        // LSB-first 0xA5
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b1);
        checkOutput("lsb par", par_out, 8'hA5);
        checkOutput("lsb valid", out_valid, 1);
        checkOutput("lsb busy", busy, 0);
        idle(1'b1);
        checkOutput("lsb valid drop", out_valid, 0);

        // MSB-first 0x3C
        sendFrame(8'h3C, 1'b1, 1'b1, 1'b1);
        checkOutput("msb par", par_out, 8'h3C);
        checkOutput("msb overrun", overrun, 0);
        idle(1'b1);

        // Backpressure: second word dropped
        sendFrame(8'h11, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        sendFrame(8'h22, 1'b0, 1'b0, 1'b0);
        checkOutput("bp par", par_out, 8'h11);
        checkOutput("bp valid", out_valid, 1);
        checkOutput("bp overrun", overrun, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("bp ovr_clr", overrun, 0);
        idle(1'b1);
        checkOutput("bp drained", out_valid, 0);

        // Resync after 3 garbage bits
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        checkOutput("resync garbage valid", out_valid, 0);
        sendFrame(8'hF0, 1'b0, 1'b1, 1'b1);
        checkOutput("resync par", par_out, 8'hF0);
        checkOutput("resync valid", out_valid, 1);
        idle(1'b1);
        checkOutput("resync single valid", out_valid, 0);

        // Accept and completion on the same edge
        sendFrame(8'h11, 1'b0, 1'b0, 1'b0);
        sendFrame(8'h22, 1'b0, 1'b0, 1'b1);
        checkOutput("simul par", par_out, 8'h22);
        checkOutput("simul valid", out_valid, 1);
        checkOutput("simul overrun", overrun, 0);
        idle(1'b1);

        // start together with the final bit: that bit opens the new frame
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        for (int k = 0; k < W - 1; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            cycle();
        end
        w81 = 8'h81;
        applyStimulus(1'b1, 1'b0, 1'b1, w81[0], 1'b1, 1'b0);
        cycle();
        checkOutput("restart busy", busy, 1);
        checkOutput("restart no word", out_valid, 0);
        for (int k = 1; k < W; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, w81[k], 1'b1, 1'b0);
            cycle();
        end
        checkOutput("restart par", par_out, 8'h81);
        idle(1'b1);

        // Asynchronous reset mid-frame with a word held
        sendFrame(8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        checkOutput("pre-reset valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async par", par_out, 0);
        checkOutput("async valid", out_valid, 0);
        checkOutput("async busy", busy, 0);
        resetModel();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sendFrame(8'h5A, 1'b0, 1'b1, 1'b1);
        checkOutput("post-reset par", par_out, 8'h5A);
        idle(1'b1);

        // Random stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            ena       = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 19) == 0);
            dir       = 1'($urandom);
            ser_valid = ($urandom_range(0, 9) < 7);
            ser_in    = 1'($urandom);
            out_ready = 1'($urandom);
            ovr_clr   = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
